// File: rtl/water_level_ctrl.sv
// Lock-chamber water level controller: a bounded up/down level counter paced by
// fill/drain prescalers. A three-state FSM (IDLE/RAISE/LOWER) drives it.
module water_level_ctrl #(
    parameter int unsigned LEVEL_W     = 8,
    parameter int unsigned LEVEL_MAX   = 80,
    parameter int unsigned HIGH_TH     = 75,
    parameter int unsigned LOW_TH      = 5,
    parameter int unsigned FILL_DIV    = 1,
    parameter int unsigned DRAIN_DIV   = 1,
    parameter int unsigned RESET_LEVEL = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               w_up,
    input  logic               w_down,
    input  logic               w_stop,
    output logic [LEVEL_W-1:0] level,
    output logic               water_high,
    output logic               water_low,
    output logic               busy,
    output logic               done
);

    localparam int unsigned DIV_MAX = (FILL_DIV > DRAIN_DIV) ? FILL_DIV : DRAIN_DIV;
    localparam int unsigned DIV_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

    localparam logic [DIV_W-1:0]   FILL_LAST  = DIV_W'(FILL_DIV - 1);
    localparam logic [DIV_W-1:0]   DRAIN_LAST = DIV_W'(DRAIN_DIV - 1);
    localparam logic [LEVEL_W-1:0] LVL_MAX    = LEVEL_W'(LEVEL_MAX);
    localparam logic [LEVEL_W-1:0] LVL_HIGH   = LEVEL_W'(HIGH_TH);
    localparam logic [LEVEL_W-1:0] LVL_LOW    = LEVEL_W'(LOW_TH);
    localparam logic [LEVEL_W-1:0] LVL_RESET  = LEVEL_W'(RESET_LEVEL);

    typedef enum logic [1:0] {
        IDLE,
        RAISE,
        LOWER
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_cnt, div_d;
    logic [LEVEL_W-1:0] level_d;
    logic               done_d;

    // State, level, prescaler and done pulse are all registered together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            level   <= LVL_RESET;
            div_cnt <= '0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            level   <= level_d;
            div_cnt <= div_d;
            done    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        level_d = level;
        div_d   = div_cnt;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                div_d = '0;
                if (w_up && !w_down && level != LVL_MAX) begin
                    state_d = RAISE;
                end else if (w_down && !w_up && level != '0) begin
                    state_d = LOWER;
                end
            end
            RAISE: begin
                if (w_stop) begin
                    state_d = IDLE;
                    div_d   = '0;
                end else if (w_down && !w_up) begin
                    state_d = LOWER;
                    div_d   = '0;
                end else if (div_cnt == FILL_LAST) begin
                    div_d   = '0;
                    level_d = level + 1'b1;
                    // Reaching the top ends the fill on the same edge as the step.
                    if (level_d == LVL_MAX) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    div_d = div_cnt + 1'b1;
                end
            end
            LOWER: begin
                if (w_stop) begin
                    state_d = IDLE;
                    div_d   = '0;
                end else if (w_up && !w_down) begin
                    state_d = RAISE;
                    div_d   = '0;
                end else if (div_cnt == DRAIN_LAST) begin
                    div_d   = '0;
                    level_d = level - 1'b1;
                    if (level_d == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    div_d = div_cnt + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                div_d   = '0;
            end
        endcase
    end

    always_comb begin
        busy       = (state_q != IDLE);
        water_high = (level >= LVL_HIGH);
        water_low  = (level <= LVL_LOW);
    end

endmodule

// File: tb/tb_water_level_ctrl.sv
// Directed bench for water_level_ctrl: default-rate instance plus a
// FILL_DIV=4 / DRAIN_DIV=3 instance, checked on the falling clock edge.
module tb_water_level_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       up1, down1, stop1;
    logic [7:0] level1;
    logic       high1, low1, busy1, done1;
    logic       up2, down2, stop2;
    logic [7:0] level2;
    logic       high2, low2, busy2, done2;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    water_level_ctrl dut1 (
        .clk(clk), .reset(reset), .w_up(up1), .w_down(down1), .w_stop(stop1),
        .level(level1), .water_high(high1), .water_low(low1), .busy(busy1), .done(done1)
    );

    water_level_ctrl #(.FILL_DIV(4), .DRAIN_DIV(3)) dut2 (
        .clk(clk), .reset(reset), .w_up(up2), .w_down(down2), .w_stop(stop2),
        .level(level2), .water_high(high2), .water_low(low2), .busy(busy2), .done(done2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Checks all dut1 outputs against an expected level, done and busy.
    task automatic chk1(input string tag, input int lvl, input bit dn, input bit bs);
        check({tag, " level"}, 32'(level1), 32'(lvl));
        check({tag, " done"},  32'(done1),  32'(dn));
        check({tag, " busy"},  32'(busy1),  32'(bs));
        check({tag, " high"},  32'(high1),  32'(lvl >= 75));
        check({tag, " low"},   32'(low1),   32'(lvl <= 5));
    endtask

    task automatic chk2(input string tag, input int lvl, input bit dn, input bit bs);
        check({tag, " level"}, 32'(level2), 32'(lvl));
        check({tag, " done"},  32'(done2),  32'(dn));
        check({tag, " busy"},  32'(busy2),  32'(bs));
    endtask

    initial begin
        reset = 1'b0;
        {up1, down1, stop1} = '0;
        {up2, down2, stop2} = '0;
        #2;
        chk1("rst1", 0, 1'b0, 1'b0);
        chk2("rst2", 0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk1("idle", 0, 1'b0, 1'b0);

        // 1: full fill at one step per cycle
        up1 = 1'b1;
        tick();
        up1 = 1'b0;
        chk1("t1 start", 0, 1'b0, 1'b1);
        for (int i = 1; i <= 80; i++) begin
            tick();
            chk1("t1 fill", i, i == 80, i != 80);
        end
        tick();
        chk1("t1 after", 80, 1'b0, 1'b0);

        // 2: full drain
        down1 = 1'b1;
        tick();
        down1 = 1'b0;
        chk1("t2 start", 80, 1'b0, 1'b1);
        for (int i = 1; i <= 80; i++) begin
            tick();
            chk1("t2 drain", 80 - i, i == 80, i != 80);
        end
        tick();
        chk1("t2 after", 0, 1'b0, 1'b0);

        // 3: reverse at 40
        up1 = 1'b1;
        tick();
        up1 = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            chk1("t3 fill", i, 1'b0, 1'b1);
        end
        down1 = 1'b1;
        tick();
        down1 = 1'b0;
        chk1("t3 reverse", 40, 1'b0, 1'b1);
        for (int i = 1; i <= 40; i++) begin
            tick();
            chk1("t3 drain", 40 - i, i == 40, i != 40);
        end

        // 4: stop at 30, then resume
        up1 = 1'b1;
        tick();
        up1 = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            chk1("t4 fill", i, 1'b0, 1'b1);
        end
        stop1 = 1'b1;
        tick();
        chk1("t4 stop", 30, 1'b0, 1'b0);
        tick();
        stop1 = 1'b0;
        chk1("t4 hold", 30, 1'b0, 1'b0);
        up1 = 1'b1;
        tick();
        up1 = 1'b0;
        chk1("t4 resume", 30, 1'b0, 1'b1);
        for (int i = 31; i <= 80; i++) begin
            tick();
            chk1("t4 fill2", i, i == 80, i != 80);
        end

        // 5: conflicting/ignored requests, then async reset mid-drain
        up1 = 1'b1;
        down1 = 1'b1;
        tick();
        chk1("t5 both", 80, 1'b0, 1'b0);
        down1 = 1'b0;
        tick();
        up1 = 1'b0;
        chk1("t5 up at max", 80, 1'b0, 1'b0);
        down1 = 1'b1;
        tick();
        down1 = 1'b0;
        chk1("t5 drain start", 80, 1'b0, 1'b1);
        for (int i = 1; i <= 30; i++) begin
            tick();
            chk1("t5 drain", 80 - i, 1'b0, 1'b1);
        end
        #2;
        reset = 1'b0;
        #1;
        chk1("t5 async rst", 0, 1'b0, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        chk1("t5 post rst", 0, 1'b0, 1'b0);

        // 6: divided rates on the second instance
        up2 = 1'b1;
        tick();
        up2 = 1'b0;
        chk2("t6 start", 0, 1'b0, 1'b1);
        for (int n = 1; n <= 320; n++) begin
            tick();
            chk2("t6 fill", n / 4, n == 320, n != 320);
        end
        tick();
        chk2("t6 full", 80, 1'b0, 1'b0);
        check("t6 high", 32'(high2), 32'd1);
        down2 = 1'b1;
        tick();
        down2 = 1'b0;
        for (int n = 1; n <= 240; n++) begin
            tick();
            chk2("t6 drain", 80 - n / 3, n == 240, n != 240);
        end
        tick();
        chk2("t6 empty", 0, 1'b0, 1'b0);
        check("t6 low", 32'(low2), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
